alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that reuses the shared 32-bit combinational ALU to run unsigned multiply (shift-add) and unsigned divide/remainder (restoring).
- Sits beside the execute stage. It drives the ALU's A/B/op inputs and reads its result, so the datapath needs no dedicated multiplier or divider.
- Uses a start/busy/done handshake. The result is held registered until the next accepted start.

Parameters:
- OP_ADD, 3'b010, ALU op code driven for accumulate.
- OP_SUB, 3'b110, ALU op code driven for trial subtract.
- OP_SLTU, 3'b111, ALU op code driven for unsigned compare (res[0] = A<B).
- DIV0_QUO, 32'hFFFF_FFFF, quotient returned on divide-by-zero.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op_div  in  1  0 = multiply, 1 = divide
- src_a  in  32  multiplicand / dividend, sampled with start
- src_b  in  32  multiplier / divisor, sampled with start
- busy  out  1  high in MUL and DIV states
- done  out  1  one-cycle pulse, high only in DONE state
- result_lo  out  32  mul: product[31:0]; div: quotient
- result_hi  out  32  mul: 0; div: remainder
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_op  out  3  to ALU operation
- alu_res  in  32  from ALU result (combinational, same cycle)

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE and all internal registers clear.
  - busy=0, done=0, result_lo=0, result_hi=0, alu_a=0, alu_b=0, alu_op=OP_ADD.
- States: IDLE, MUL, DIV, DONE. A 6-bit iteration counter and a 1-bit div phase (CMP/SUB) are used.
- IDLE:
  - ALU outputs are driven A=B=0, op=OP_ADD.
  - start=1 latches the operands and selects the next state:
    - op_div=0: acc<=0, mcand<=src_a, mplier<=src_b, go to MUL.
    - op_div=1, src_b≠0: rem<=0, quo<=src_a, dvsr<=src_b, phase<=CMP, go to DIV.
    - op_div=1, src_b=0: result_lo<=DIV0_QUO, result_hi<=src_a, go straight to DONE. No ALU use.
- MUL (exactly 32 cycles):
  - alu_op=OP_ADD, alu_a=acc, alu_b=mcand.
  - If mplier[0]=1, acc<=alu_res.
  - Every cycle: mcand<=mcand<<1, mplier<=mplier>>1.
  - After the 32nd cycle: result_lo<=final acc (low 32 bits, wrap mod 2^32), result_hi<=0, go to DONE.
- DIV (32 bits × 2 cycles = 64 cycles):
  - CMP cycle:
    - trial={rem[30:0],quo[31]}.
    - alu_op=OP_SLTU, alu_a=trial, alu_b=dvsr.
    - rem<=trial, quo<=quo<<1, lt<=alu_res[0].
  - SUB cycle:
    - alu_op=OP_SUB, alu_a=rem, alu_b=dvsr.
    - If lt=0: rem<=alu_res, quo[0]<=1.
  - rem<2^k after k bits, so rem[31]=0 before every shift. 32-bit arithmetic is exact; no carry bit is needed.
  - After the 64th cycle: result_lo<=quo, result_hi<=rem, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then back to IDLE.
  - start is ignored in DONE; it is accepted again from IDLE on the next cycle.
- Latency, with start sampled at edge 0:
  - mul: done in cycle 33.
  - div: done in cycle 65.
  - div-by-zero: done in cycle 1.
- busy=1 exactly in MUL/DIV cycles. start while busy or done is ignored, and the operands are not re-latched.
- result_lo/result_hi change only on entry to DONE and are stable otherwise, including across IDLE.
- Operands are captured at start. src_a/src_b changes mid-operation have no effect.

Test Plan:
- Reset, then mul src_a=7, src_b=6 -> busy cycles 1–32, done cycle 33, result_lo=42, result_hi=0.
- mul 0xFFFFFFFF×0xFFFFFFFF -> result_lo=0x00000001, result_hi=0. Also mul 0×0x12345678 -> result_lo=0.
- div 100/7 -> busy cycles 1–64, done cycle 65, result_lo=14, result_hi=2. Also div 0xFFFFFFFF/0xFFFFFFFE -> q=1, r=1.
- div 1234/0 -> done cycle 1, busy never high, result_lo=0xFFFFFFFF, result_hi=1234.
- start pulsed (op_div=1, 5/2) at cycle 10 of a running 7×6 multiply -> ignored, result 42. A fresh start after done gives q=2, r=1.
- rst_n low at cycle 20 of a divide, release 2 cycles later -> busy=0, done=0, results=0. A next mul 3×3 gives 9.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) and divide (restoring) sequencer that borrows
// the shared combinational ALU instead of owning a multiplier or divider.
module alu_muldiv_seq #(
    parameter logic [2:0]  OP_ADD   = 3'b010,
    parameter logic [2:0]  OP_SUB   = 3'b110,
    parameter logic [2:0]  OP_SLTU  = 3'b111,
    parameter logic [31:0] DIV0_QUO = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_op_div,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result_lo,
    output logic [31:0] o_result_hi,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [2:0]  o_alu_op,
    input  logic [31:0] i_alu_res
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic PH_CMP = 1'b0;
    localparam logic PH_SUB = 1'b1;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_phase;
    logic        r_lt;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic [31:0] r_res_lo;
    logic [31:0] r_res_hi;

    logic [31:0] w_trial;
    logic [31:0] w_acc_nxt;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic        w_last;

    // rem never reaches 2^31 before a shift, so dropping rem[31] loses nothing.
    assign w_trial   = {r_rem[30:0], r_quo[31]};
    assign w_acc_nxt = r_mplier[0] ? i_alu_res : r_acc;
    assign w_rem_nxt = r_lt ? r_rem : i_alu_res;
    assign w_quo_nxt = {r_quo[31:1], r_quo[0] | ~r_lt};
    assign w_last    = (r_cnt == 6'd31);

    assign o_busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign o_done      = (r_state == ST_DONE);
    assign o_result_lo = r_res_lo;
    assign o_result_hi = r_res_hi;

    always_comb begin
        o_alu_a  = 32'd0;
        o_alu_b  = 32'd0;
        o_alu_op = OP_ADD;
        case (r_state)
            ST_MUL: begin
                o_alu_a  = r_acc;
                o_alu_b  = r_mcand;
            end
            ST_DIV: begin
                o_alu_b = r_dvsr;
                if (r_phase == PH_CMP) begin
                    o_alu_op = OP_SLTU;
                    o_alu_a  = w_trial;
                end else begin
                    o_alu_op = OP_SUB;
                    o_alu_a  = r_rem;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 6'd0;
            r_phase  <= PH_CMP;
            r_lt     <= 1'b0;
            r_acc    <= 32'd0;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvsr   <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_hi <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt <= 6'd0;
                        if (!i_op_div) begin
                            r_acc    <= 32'd0;
                            r_mcand  <= i_src_a;
                            r_mplier <= i_src_b;
                            r_state  <= ST_MUL;
                        end else if (i_src_b != 32'd0) begin
                            r_rem   <= 32'd0;
                            r_quo   <= i_src_a;
                            r_dvsr  <= i_src_b;
                            r_phase <= PH_CMP;
                            r_state <= ST_DIV;
                        end else begin
                            r_res_lo <= DIV0_QUO;
                            r_res_hi <= i_src_a;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_res_lo <= w_acc_nxt;
                        r_res_hi <= 32'd0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (r_phase == PH_CMP) begin
                        r_rem   <= w_trial;
                        r_quo   <= r_quo << 1;
                        r_lt    <= i_alu_res[0];
                        r_phase <= PH_SUB;
                    end else begin
                        r_rem   <= w_rem_nxt;
                        r_quo   <= w_quo_nxt;
                        r_phase <= PH_CMP;
                        r_cnt   <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_res_lo <= w_quo_nxt;
                            r_res_hi <= w_rem_nxt;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: a small ALU model closes the loop, a vector table covers
// mul/div/div0, and hand-written sequences cover ignored start and mid-operation reset.
module tb_alu_muldiv_seq;

    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_div;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_res;

    int n_tests = 0;
    int n_fail  = 0;

    alu_muldiv_seq u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_op_div    (op_div),
        .i_src_a     (src_a),
        .i_src_b     (src_b),
        .o_busy      (busy),
        .o_done      (done),
        .o_result_lo (result_lo),
        .o_result_hi (result_hi),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .i_alu_res   (alu_res)
    );

    // Reference shared ALU.
    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_SLTU: alu_res = {31'd0, alu_a < alu_b};
            default: alu_res = 32'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue a start at the next edge (edge 0); returns #1 into cycle 1.
    task automatic start_op(input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op_div = d;
        src_a  = a;
        src_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advance until done (bounded); reports the done cycle and busy cycles seen from cyc0 on.
    task automatic wait_done(input int cyc0, output int cyc, output int nbusy);
        cyc   = cyc0;
        nbusy = 0;
        while (!done && cyc <= 100) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int cyc;
        int nbusy;
        start_op(v.op_div, v.a, v.b);
        src_a = ~v.a;
        src_b = ~v.b;
        wait_done(1, cyc, nbusy);
        check({name, " done_cycle"}, cyc, v.lat);
        check({name, " busy_cycles"}, nbusy, v.lat - 1);
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check({name, " lo"}, result_lo, v.exp_lo);
        check({name, " hi"}, result_hi, v.exp_hi);
        @(posedge clk);
        #1;
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
        check({name, " lo_held"}, result_lo, v.exp_lo);
    endtask

    vec_t vecs[10];

    initial begin
        int cyc;
        int nbusy;
        vec_t v;

        vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd42,         32'd0,    33};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'd0,    33};
        vecs[2] = '{1'b0, 32'd0,          32'h1234_5678,  32'd0,          32'd0,    33};
        vecs[3] = '{1'b0, 32'h1234_5678,  32'h10,         32'h2345_6780,  32'd0,    33};
        vecs[4] = '{1'b0, 32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF,  32'd0,    33};
        vecs[5] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,    65};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,    65};
        vecs[7] = '{1'b1, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,    65};
        vecs[8] = '{1'b1, 32'd13,         32'd20,         32'd0,          32'd13,   65};
        vecs[9] = '{1'b1, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1};

        rst_n  = 1'b0;
        start  = 1'b0;
        op_div = 1'b0;
        src_a  = 32'd0;
        src_b  = 32'd0;
        #12;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst lo", result_lo, 32'd0);
        check("rst hi", result_hi, 32'd0);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_op", {29'd0, alu_op}, {29'd0, OP_ADD});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start (div 5/2) pulsed in cycle 10 of a 7x6 multiply must be ignored.
        start_op(1'b0, 32'd7, 32'd6);
        for (int c = 1; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        op_div = 1'b1;
        src_a  = 32'd5;
        src_b  = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(11, cyc, nbusy);
        check("ign done_cycle", cyc, 33);
        check("ign busy_cycles", nbusy, 22);
        check("ign lo", result_lo, 32'd42);
        check("ign hi", result_hi, 32'd0);
        @(posedge clk);
        #1;
        v = '{1'b1, 32'd5, 32'd2, 32'd2, 32'd1, 65};
        run_vec(v, "after_ign");

        // Reset asserted in cycle 20 of 100/7, held two cycles.
        start_op(1'b1, 32'd100, 32'd7);
        for (int c = 1; c < 20; c++) begin
            @(posedge clk);
            #1;
        end
        check("mid busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid busy", {31'd0, busy}, 32'd0);
        check("mid done", {31'd0, done}, 32'd0);
        check("mid lo", result_lo, 32'd0);
        check("mid hi", result_hi, 32'd0);
        check("mid alu_op", {29'd0, alu_op}, {29'd0, OP_ADD});
        check("mid alu_a", alu_a, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst busy", {31'd0, busy}, 32'd0);
        check("post_rst done", {31'd0, done}, 32'd0);
        check("post_rst lo", result_lo, 32'd0);
        v = '{1'b0, 32'd3, 32'd3, 32'd9, 32'd0, 33};
        run_vec(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
